// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the iterative divider
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence one bit beyond log2.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring shift-subtract step
import seq_divider_pkg::*;

module seq_divider_div_step #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             qbit
);

    logic [WIDTH:0] t;

    // Trial subtract; a clear borrow bit means the divisor fits and the
    // difference becomes the new partial remainder, otherwise restore S.
    // Either result is below the divisor, so WIDTH bits always suffice.
    always_comb begin
        t      = s - {1'b0, d};
        qbit   = ~t[WIDTH];
        r_next = qbit ? t[WIDTH-1:0] : s[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider with start/done handshake
import seq_divider_pkg::*;

module seq_divider #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divzero
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    // Partial remainder is kept WIDTH bits wide: it is always below the
    // divisor, so the extra top bit of the textbook R register is always 0.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r_next;
    logic             qbit;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;

    // Shift the next dividend bit into the remainder and form the next quotient.
    always_comb begin
        s         = {r, q[WIDTH-1]};
        q_next    = {q[WIDTH-2:0], qbit};
        last_iter = (count == CW'(WIDTH - 1));
    end

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .s      (s),
        .d      (d),
        .r_next (r_next),
        .qbit   (qbit)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divzero   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (inputB != '0) begin
                            r       <= '0;
                            q       <= inputA;
                            d       <= inputB;
                            count   <= '0;
                            divzero <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            // Divide by zero skips iteration and answers at once.
                            quotient  <= '1;
                            remainder <= inputA;
                            divzero   <= 1'b1;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divzero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divzero   (divzero)
    );

    always #5 clk = ~clk;

    // Launch one division and observe until done; lat counts negedges after start.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_cycles, output logic overlap);
        @(negedge clk);
        start  = 1'b1;
        inputA = a;
        inputB = b;
        @(negedge clk);
        start       = 1'b0;
        inputA      = $urandom;
        inputB      = $urandom;
        busy_cycles = 0;
        overlap     = 1'b0;
        for (lat = 1; lat < 100; lat++) begin
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cycles++;
            if (done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        inputA = '0;
        inputB = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, divzero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
                     busy, done, divzero, quotient, remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic ov;
        run_div(32'd100, 32'd7, lat, bc, ov);
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL basic_latency: done after %0d edges, expected %0d", lat - 1, W);
        end
        checks++;
        if (bc !== W) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, W);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done_overlap: got %b, expected 0", ov);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || divzero !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b, expected q=14 r=2 dz=0",
                     quotient, remainder, divzero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%b q=%0d r=%0d, expected done=0 q=14 r=2",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        int lat, bc;
        logic ov;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
        ta[2] = 32'd3;         tb[2] = 32'd10;
        ta[3] = 32'd0;         tb[3] = 32'd5;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], lat, bc, ov);
            checks++;
            if (lat !== W + 1 || quotient !== ta[i] / tb[i] || remainder !== ta[i] % tb[i]
                || divzero !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d (%h/%h): lat=%0d q=%h r=%h dz=%b, expected lat=%0d q=%h r=%h dz=0",
                         i, ta[i], tb[i], lat, quotient, remainder, divzero, W + 1,
                         ta[i] / tb[i], ta[i] % tb[i]);
            end
        end
    endtask

    task automatic test_divzero();
        int lat, bc;
        logic ov;
        run_div(32'd5, 32'd0, lat, bc, ov);
        checks++;
        if (lat !== 1 || divzero !== 1'b1) begin
            errors++;
            $display("FAIL divzero_timing: lat=%0d dz=%b, expected lat=1 dz=1", lat, divzero);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin
            errors++;
            $display("FAIL divzero_result: q=%h r=%h, expected q=ffffffff r=5", quotient, remainder);
        end
        checks++;
        if (bc !== 0) begin
            errors++;
            $display("FAIL divzero_busy: busy cycles=%0d, expected 0", bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || divzero !== 1'b1) begin
            errors++;
            $display("FAIL divzero_after: done=%b busy=%b dz=%b, expected done=0 busy=0 dz=1",
                     done, busy, divzero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start  = 1'b1;
        inputA = 32'd100;
        inputB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start  = 1'b1;
        inputA = 32'd50;
        inputB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (lat = 0; lat < 100 && !done; lat++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL restart_ignored: done=%b q=%0d r=%0d, expected done=1 q=14 r=2",
                     done, quotient, remainder);
        end
        // One negedge later the FSM sits in IDLE; start is sampled at the next edge.
        @(negedge clk);
        start  = 1'b1;
        inputA = 32'd50;
        inputB = 32'd3;
        @(negedge clk);
        start  = 1'b0;
        inputA = '0;
        inputB = '0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        for (lat = 1; lat < 100 && !done; lat++) @(negedge clk);
        checks++;
        if (lat !== W + 1 || quotient !== 32'd16 || remainder !== 32'd2 || divzero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_50_3: lat=%0d q=%0d r=%0d dz=%b, expected lat=%0d q=16 r=2 dz=0",
                     lat, quotient, remainder, divzero, W + 1);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, bc, seen;
        logic ov;
        @(negedge clk);
        start  = 1'b1;
        inputA = 32'd100;
        inputB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, divzero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
                     busy, done, divzero, quotient, remainder);
        end
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d cycles with busy/done, expected 0", seen);
        end
        run_div(32'd9, 32'd4, lat, bc, ov);
        checks++;
        if (quotient !== 32'd2 || remainder !== 32'd1 || lat !== W + 1) begin
            errors++;
            $display("FAIL after_reset_9_4: lat=%0d q=%0d r=%0d, expected lat=%0d q=2 r=1",
                     lat, quotient, remainder, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic edz;
        int lat, bc, elat;
        logic ov;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (i % 3 == 1) a = $urandom_range(0, 1000);
            case (i % 4)
                0: b = $urandom_range(1, 255);
                1: b = $urandom;
                2: b = (i % 8 == 6) ? 32'd0 : $urandom_range(1, 65535);
                default: b = $urandom | 32'h8000_0000;
            endcase
            edz  = (b == 0);
            eq   = edz ? 32'hFFFF_FFFF : a / b;
            er   = edz ? a : a % b;
            elat = edz ? 1 : W + 1;
            run_div(a, b, lat, bc, ov);
            checks++;
            if (quotient !== eq || remainder !== er || divzero !== edz || lat !== elat || ov !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d (%h/%h): q=%h r=%h dz=%b lat=%0d ov=%b, expected q=%h r=%h dz=%b lat=%0d ov=0",
                         i, a, b, quotient, remainder, divzero, lat, ov, eq, er, edz, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_divzero();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
